// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage IF/ID/EXE/MEM/WB pipe.
// Holds the per-stage valid bits, builds the allow_in handshake chain,
// drives the inter-stage latch enables and runs a RUN/DRAIN/IDLE FSM.
module pipe_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter logic [4:0]  CANCEL_MASK = 5'b00011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             cancel,
    input  logic [4:0]       stage_over,
    input  logic             id_hazard,
    output logic [4:0]       stage_valid,
    output logic [3:0]       latch_en,
    output logic             next_fetch,
    output logic             busy,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] v;
    logic [4:0] over_e;
    logic [5:0] allow_in;
    logic [4:0] kill;
    logic [4:0] to_next;

    // Handshake chain: allow_in ripples from WB back towards IF.
    always_comb begin
        over_e   = stage_over;
        over_e[1] = stage_over[1] & ~id_hazard;
        kill     = CANCEL_MASK & {5{cancel}};
        allow_in = '0;
        allow_in[5] = 1'b1;
        for (int unsigned j = 0; j < 5; j++) begin
            allow_in[4-j] = ~v[4-j] | (over_e[4-j] & allow_in[5-j]);
        end
        for (int unsigned i = 0; i < 5; i++) begin
            to_next[i] = v[i] & over_e[i] & allow_in[i+1] & ~kill[i];
        end
    end

    assign next_fetch  = (state == RUN) & allow_in[0];
    assign latch_en    = to_next[3:0];
    assign stage_valid = v;
    assign ctrl_state  = state;
    assign busy        = (state != IDLE) | (|v);

    // Valid bits: kill beats an incoming instruction, which beats departure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else begin
            if (kill[0])          v[0] <= 1'b0;
            else if (next_fetch)  v[0] <= 1'b1;
            else if (to_next[0])  v[0] <= 1'b0;
            for (int unsigned i = 1; i < 5; i++) begin
                if (kill[i])            v[i] <= 1'b0;
                else if (to_next[i-1])  v[i] <= 1'b1;
                else if (to_next[i])    v[i] <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: halt is only seen in RUN, so start+halt in IDLE goes RUN first.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (halt)  state_nxt = DRAIN;
            DRAIN: begin
                if (v == '0)              state_nxt = IDLE;
                else if (start && !halt)  state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Performance counters, free-wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state == RUN || state == DRAIN) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (to_next[4])                     retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fill, hazard, MEM stall, cancel,
// halt/drain with retire counter wrap (CNT_W=4), asynchronous reset.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, halt, cancel, id_hazard;
    logic [4:0] stage_over;
    logic [4:0] stage_valid;
    logic [3:0] latch_en;
    logic       next_fetch, busy;
    logic [1:0] ctrl_state;
    logic [3:0] cycle_cnt, retire_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    pipe_ctrl #(.CNT_W(4), .CANCEL_MASK(5'b00011)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .cancel(cancel),
        .stage_over(stage_over), .id_hazard(id_hazard),
        .stage_valid(stage_valid), .latch_en(latch_en), .next_fetch(next_fetch),
        .busy(busy), .ctrl_state(ctrl_state), .cycle_cnt(cycle_cnt),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; cancel = 1'b0;
        id_hazard = 1'b0; stage_over = 5'h00;
        #2;
        check("rst_valid", stage_valid, 5'h00);
        check("rst_state", ctrl_state, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_fetch", next_fetch, 1'b0);
        check("rst_latch", latch_en, 4'h0);
        check("rst_cyc", cycle_cnt, 4'd0);
        check("rst_ret", retire_cnt, 4'd0);
        step();
        rst = 1'b0;

        // Fill
        start = 1'b1; stage_over = 5'h1F;
        step();
        start = 1'b0;
        check("fill_state", ctrl_state, 2'd1);
        check("fill_fetch", next_fetch, 1'b1);
        check("fill_cyc0", cycle_cnt, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("fill_valid", stage_valid, (32'd1 << k) - 32'd1);
            check("fill_ret0", retire_cnt, 4'd0);
        end
        step();
        check("first_retire", retire_cnt, 4'd1);
        step();
        check("second_retire", retire_cnt, 4'd2);
        check("cyc7", cycle_cnt, 4'd7);

        // Hazard on ID for two cycles
        id_hazard = 1'b1;
        #1;
        check("haz1_latch", latch_en, 4'hC);
        check("haz1_fetch", next_fetch, 1'b0);
        step();
        check("haz1_valid", stage_valid, 5'h1B);
        check("haz2_latch", latch_en, 4'h8);
        check("haz2_fetch", next_fetch, 1'b0);
        step();
        check("haz2_valid", stage_valid, 5'h13);
        id_hazard = 1'b0;
        #1;
        check("resume_latch", latch_en, 4'h3);
        check("resume_fetch", next_fetch, 1'b1);
        step();
        check("resume_valid", stage_valid, 5'h07);
        check("resume_ret", retire_cnt, 4'd5);
        step();
        step();
        check("refill_valid", stage_valid, 5'h1F);
        check("refill_ret", retire_cnt, 4'd5);
        check("cyc12", cycle_cnt, 4'd12);

        // MEM stall for three cycles
        stage_over = 5'b10111;
        #1;
        check("stall_latch", latch_en, 4'h0);
        check("stall_fetch", next_fetch, 1'b0);
        step();
        check("stall1_valid", stage_valid, 5'h0F);
        check("stall1_ret", retire_cnt, 4'd6);
        step();
        check("stall2_latch", latch_en, 4'h0);
        check("stall2_ret", retire_cnt, 4'd6);
        step();
        check("stall3_valid", stage_valid, 5'h0F);
        check("stall3_ret", retire_cnt, 4'd6);
        stage_over = 5'h1F;
        #1;
        check("unstall_latch", latch_en, 4'hF);
        step();
        check("unstall_valid", stage_valid, 5'h1F);
        check("cyc_wrap", cycle_cnt, 4'd0);

        // Cancel IF/ID
        cancel = 1'b1;
        #1;
        check("cancel_latch", latch_en, 4'hC);
        step();
        cancel = 1'b0;
        check("cancel_valid", stage_valid, 5'h18);
        check("cancel_ret", retire_cnt, 4'd7);
        step();
        check("post_cancel_valid", stage_valid, 5'h11);
        check("post_cancel_ret", retire_cnt, 4'd8);
        repeat (4) step();
        check("recover_valid", stage_valid, 5'h1F);
        check("recover_ret", retire_cnt, 4'd9);
        step();
        check("recover_ret2", retire_cnt, 4'd10);

        // Halt and drain; retire counter wraps 15 -> 0
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("drain_state", ctrl_state, 2'd2);
        check("drain_fetch", next_fetch, 1'b0);
        check("drain_valid", stage_valid, 5'h1F);
        check("drain_ret", retire_cnt, 4'd11);
        step();
        check("drain1_valid", stage_valid, 5'h1E);
        repeat (3) step();
        check("drain4_valid", stage_valid, 5'h10);
        check("ret15", retire_cnt, 4'd15);
        step();
        check("drain_empty", stage_valid, 5'h00);
        check("ret_wrap", retire_cnt, 4'd0);
        check("busy_empty", busy, 1'b1);
        step();
        check("idle_state", ctrl_state, 2'd0);
        check("idle_busy", busy, 1'b0);
        check("cyc30", cycle_cnt, 4'd14);
        step();
        check("idle_cyc_hold", cycle_cnt, 4'd14);

        // Restart, halt, then async reset in DRAIN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("pre_rst_state", ctrl_state, 2'd2);
        check("pre_rst_valid", stage_valid, 5'h07);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", stage_valid, 5'h00);
        check("arst_state", ctrl_state, 2'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_latch", latch_en, 4'h0);
        check("arst_cyc", cycle_cnt, 4'd0);
        check("arst_ret", retire_cnt, 4'd0);
        step();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
